// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: raster-scan a feature map from 1-cycle-latency SRAM onto a valid/ready stream with x/y/ch tags
//   clk/rst            : clock, synchronous active-high reset
//   start/running/done : launch request, busy flag, end-of-map pulse
//   mem_re/mem_addr/mem_rdata : SRAM read port
//   out_*              : stream word, coordinates and valid/ready handshake
module fmap_stream_tx #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int NB_CHANNELS        = 2,
  localparam int TOTAL      = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * NB_CHANNELS,
  localparam int ADDR_WIDTH = TOTAL > 1 ? $clog2(TOTAL) : 1,
  localparam int XW         = FEATURE_MAP_WIDTH > 1 ? $clog2(FEATURE_MAP_WIDTH) : 1,
  localparam int YW         = FEATURE_MAP_HEIGHT > 1 ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int CW         = NB_CHANNELS > 1 ? $clog2(NB_CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  running,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XW-1:0]         out_x,
  output logic [YW-1:0]         out_y,
  output logic [CW-1:0]         out_ch
);
  localparam int PW = DATA_WIDTH + XW + YW + CW;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [XW-1:0] r_x, r_rx;
  logic [YW-1:0] r_y, r_ry;
  logic [CW-1:0] r_ch, r_rch;
  logic r_rvalid, r_wp, r_rp, r_done;
  logic [1:0] r_cnt, w_pend;
  logic [PW-1:0] r_fifo [2];
  logic [PW-1:0] w_in, w_head;
  logic w_push, w_pop, w_hs, w_last_rd, w_last_hs, w_ch_wrap, w_x_wrap;
  // An empty buffer passes the returning read straight through, so the word
  // appears the cycle the SRAM delivers it; it is captured if not accepted.
  assign w_in      = {mem_rdata, r_rx, r_ry, r_rch};
  assign w_head    = r_cnt != 2'd0 ? r_fifo[r_rp] : r_rvalid ? w_in : '0;
  assign {out_data, out_x, out_y, out_ch} = w_head;
  assign out_valid = r_cnt != 2'd0 || r_rvalid;
  assign w_hs      = out_valid && out_ready;
  assign w_pop     = r_cnt != 2'd0 && out_ready;
  assign w_push    = r_rvalid && (r_cnt != 2'd0 || !out_ready);
  assign w_pend    = r_cnt + {1'b0, r_rvalid};
  assign mem_re    = r_state == RUN && w_pend < 2'd2;
  assign mem_addr  = r_addr;
  assign w_ch_wrap = r_ch == CW'(NB_CHANNELS - 1);
  assign w_x_wrap  = r_x == XW'(FEATURE_MAP_WIDTH - 1);
  assign w_last_rd = mem_re && r_addr == ADDR_WIDTH'(TOTAL - 1);
  // In DRAIN no reads are issued, so one pending word left means this is the last.
  assign w_last_hs = r_state == DRAIN && w_hs && w_pend == 2'd1;
  assign running   = r_state != IDLE;
  assign done      = r_done;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (start ? RUN : IDLE) :
             r_state == RUN  ? (w_last_rd ? DRAIN : RUN) :
                               (w_last_hs ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
    r_done  <= rst ? 1'b0 : w_last_hs;
  end
  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE && start) || w_last_rd) begin
      r_addr <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_ch   <= '0;
    end else if (mem_re) begin
      r_addr <= r_addr + ADDR_WIDTH'(1);
      r_ch   <= w_ch_wrap ? '0 : r_ch + CW'(1);
      r_x    <= w_ch_wrap ? (w_x_wrap ? '0 : r_x + XW'(1)) : r_x;
      r_y    <= w_ch_wrap && w_x_wrap ? r_y + YW'(1) : r_y;
    end
  end
  always_ff @(posedge clk) begin
    r_rvalid <= rst ? 1'b0 : mem_re;
    r_rx     <= r_x;
    r_ry     <= r_y;
    r_rch    <= r_ch;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      r_wp  <= w_push ? ~r_wp : r_wp;
      r_rp  <= w_pop ? ~r_rp : r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wp] <= w_in;
endmodule

// File: tb/tb_fmap_stream_tx.sv
// tb_fmap_stream_tx: directed checks of fmap_stream_tx on a 4x3x2 map and a 1x1x1 map
module tb_fmap_stream_tx;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic running, done, mem_re, out_valid, out_ch;
  logic [4:0] mem_addr;
  logic [15:0] mem_rdata = '0, out_data;
  logic [1:0] out_x, out_y;
  logic start1 = 1'b0, ready1 = 1'b1, running1, done1, mem_re1, valid1, x1, y1, ch1;
  logic [0:0] mem_addr1;
  logic [15:0] rdata1 = '0, data1;
  int n_vec = 0, n_err = 0;
  int exp_i = 0, rd_i = 0, outst = 0, hs_n = 0, rd_n = 0, h0, r0;
  logic stall = 1'b0;
  logic [20:0] prev = '0;

  always #5 clk = ~clk;

  fmap_stream_tx #(.DATA_WIDTH(16), .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(3), .NB_CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .running(running), .done(done),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_ch(out_ch));

  fmap_stream_tx #(.DATA_WIDTH(16), .FEATURE_MAP_WIDTH(1), .FEATURE_MAP_HEIGHT(1), .NB_CHANNELS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .running(running1), .done(done1),
    .mem_re(mem_re1), .mem_addr(mem_addr1), .mem_rdata(rdata1),
    .out_data(data1), .out_valid(valid1), .out_ready(ready1),
    .out_x(x1), .out_y(y1), .out_ch(ch1));

  always @(posedge clk) begin
    mem_rdata <= mem_re ? 16'(mem_addr) : 16'hDEAD;
    rdata1    <= mem_re1 ? 16'hBEEF : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_i = 0; rd_i = 0; outst = 0; stall = 1'b0;
    end else begin
      if (stall) chk("hold", 32'({out_valid, out_data, out_x, out_y, out_ch}), 32'({1'b1, prev}));
      if (mem_re) begin
        chk("credit", 32'(outst > 1), 32'd0);
        chk("raddr", 32'(mem_addr), 32'(rd_i));
        rd_i = (rd_i + 1) % 24;
        rd_n++;
      end
      if (out_valid && out_ready) begin
        chk("sdata", 32'(out_data), 32'(exp_i));
        chk("sx", 32'(out_x), 32'((exp_i / 2) % 4));
        chk("sy", 32'(out_y), 32'(exp_i / 8));
        chk("sch", 32'(out_ch), 32'(exp_i % 2));
        exp_i = (exp_i + 1) % 24;
        hs_n++;
      end
      outst = outst + int'(mem_re) - int'(out_valid && out_ready);
      stall = out_valid && !out_ready;
      prev  = {out_data, out_x, out_y, out_ch};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step;
    chk("rst_run", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_re", 32'(mem_re), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_out", 32'({out_data, out_x, out_y, out_ch}), 0);
    rst = 1'b0;
    step;
    // full-rate stream
    start = 1'b1; step; start = 1'b0;
    chk("t1_run", 32'(running), 1);
    chk("t1_v_c1", 32'(out_valid), 0);
    step;
    for (int k = 0; k < 24; k++) begin
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_data", 32'(out_data), 32'(k));
      step;
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_run_end", 32'(running), 0);
    chk("t1_v_end", 32'(out_valid), 0);
    step;
    chk("t1_done_pulse", 32'(done), 0);
    // random backpressure
    h0 = hs_n;
    start = 1'b1; step; start = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step;
    end
    out_ready = 1'b1;
    chk("t2_done", 32'(done), 1);
    chk("t2_count", 32'(hs_n - h0), 24);
    step;
    // full stall then release
    out_ready = 1'b0;
    r0 = rd_n;
    start = 1'b1; step; start = 1'b0;
    repeat (10) step;
    chk("t3_reads", 32'(rd_n - r0), 2);
    chk("t3_valid", 32'(out_valid), 1);
    chk("t3_data", 32'(out_data), 0);
    chk("t3_re", 32'(mem_re), 0);
    out_ready = 1'b1;
    step;
    for (int k = 1; k < 5; k++) begin
      chk("t3_rvalid", 32'(out_valid), 1);
      chk("t3_rdata", 32'(out_data), 32'(k));
      step;
    end
    for (int i = 0; i < 100 && !done; i++) step;
    chk("t3_done", 32'(done), 1);
    step;
    // ignored starts, then a start in the done cycle
    h0 = hs_n;
    start = 1'b1; step; start = 1'b0;
    for (int i = 0; i < 50 && !(out_valid && out_data == 16'd5); i++) step;
    chk("t4_w5", 32'(out_data), 5);
    start = 1'b1; step; start = 1'b0;
    for (int i = 0; i < 50 && !(out_valid && out_data == 16'd23); i++) step;
    chk("t4_w23", 32'(out_data), 23);
    start = 1'b1; step; start = 1'b0;
    chk("t4_done1", 32'(done), 1);
    chk("t4_count1", 32'(hs_n - h0), 24);
    start = 1'b1; step; start = 1'b0;
    chk("t4_rerun", 32'(running), 1);
    for (int i = 0; i < 100 && !done; i++) step;
    chk("t4_done2", 32'(done), 1);
    chk("t4_count2", 32'(hs_n - h0), 48);
    step;
    // reset mid-stream
    start = 1'b1; step; start = 1'b0;
    for (int i = 0; i < 50 && !(out_valid && out_data == 16'd10); i++) step;
    chk("t5_w10", 32'(out_data), 10);
    step;
    rst = 1'b1; step; rst = 1'b0;
    chk("t5_run", 32'(running), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_re", 32'(mem_re), 0);
    chk("t5_out", 32'({out_data, out_x, out_y, out_ch}), 0);
    start = 1'b1; step; start = 1'b0;
    step;
    chk("t5_valid2", 32'(out_valid), 1);
    chk("t5_first", 32'({out_data, out_x, out_y, out_ch}), 0);
    for (int i = 0; i < 100 && !done; i++) step;
    chk("t5_done", 32'(done), 1);
    step;
    // 1x1x1 map
    start1 = 1'b1; step; start1 = 1'b0;
    chk("t6_run", 32'(running1), 1);
    chk("t6_v_c1", 32'(valid1), 0);
    step;
    chk("t6_valid", 32'(valid1), 1);
    chk("t6_data", 32'(data1), 32'h0000BEEF);
    chk("t6_xyc", 32'({x1, y1, ch1}), 0);
    step;
    chk("t6_done", 32'(done1), 1);
    chk("t6_v_end", 32'(valid1), 0);
    chk("t6_run_end", 32'(running1), 0);
    step;
    chk("t6_done_pulse", 32'(done1), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
